// File: rtl/fft_input_framer.sv
// rtl/fft_input_framer.sv - real-sample FIFO and frame delimiter feeding the FFT stage
//
// Purpose:
//   Buffers 16-bit real samples in a first-word-fall-through FIFO and streams
//   them out as 32-bit complex words {im=0, re=sample}. Words are grouped into
//   FRAME_LEN-point frames; o_data_last marks the final word of each frame.
//   A flush zero-pads the current partial frame so the FFT only ever receives
//   whole frames. Samples offered while the FIFO is full are dropped and
//   reported through the sticky o_overflow flag.
//
// Ports:
//   i_clk           clock, rising edge
//   i_rst_n         asynchronous active-low reset
//   i_start         pulse: IDLE -> STREAM, clears o_overflow
//   i_flush         pulse: STREAM -> PAD (finish frame with zero words)
//   i_sample        16-bit two's complement input sample
//   i_sample_valid  input sample present
//   o_sample_ready  input accepted on valid && ready
//   o_data          {16'h0000, sample} or 32'h0 pad word
//   o_data_valid    output word present
//   i_data_ready    downstream accepts on valid && ready
//   o_data_last     last word of a frame
//   o_frame_count   completed frames (wraps)
//   o_overflow      sticky dropped-sample flag
//   o_busy          state != IDLE

module fft_input_framer #(
  parameter int FRAME_LEN  = 1024,
  parameter int LOG2_FRAME = 10,
  parameter int FIFO_DEPTH = 16,
  parameter int LOG2_DEPTH = 4
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_start,
  input  logic        i_flush,
  input  logic [15:0] i_sample,
  input  logic        i_sample_valid,
  output logic        o_sample_ready,
  output logic [31:0] o_data,
  output logic        o_data_valid,
  input  logic        i_data_ready,
  output logic        o_data_last,
  output logic [15:0] o_frame_count,
  output logic        o_overflow,
  output logic        o_busy
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_STREAM = 2'd1,
    S_PAD    = 2'd2
  } state_e;

  localparam logic [LOG2_DEPTH:0]   DEPTH_CNT = (LOG2_DEPTH+1)'(FIFO_DEPTH);
  localparam logic [LOG2_FRAME-1:0] LAST_IDX  = LOG2_FRAME'(FRAME_LEN - 1);

  state_e                state_q, state_d;
  logic [LOG2_DEPTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [LOG2_DEPTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [LOG2_DEPTH:0]   count_q, count_d;
  logic [LOG2_FRAME-1:0] index_q, index_d;
  logic [15:0]           frame_cnt_q, frame_cnt_d;
  logic                  overflow_q, overflow_d;
  logic                  ready_q, ready_d;
  logic                  valid_q, valid_d;
  logic                  last_q, last_d;

  logic [15:0]           mem_q [FIFO_DEPTH];

  logic fifo_empty;
  logic fifo_full;
  logic push;
  logic pop;
  logic hs;
  logic hs_last;
  logic ovf_set;

  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == DEPTH_CNT);

  // ready_q is precomputed as (STREAM && !full) for the current cycle, so the
  // push decision never depends combinationally on the downstream ready.
  assign push    = ready_q && i_sample_valid;
  assign hs      = valid_q && i_data_ready;
  // Pad words are synthesised, not read from the FIFO, so they do not pop.
  assign pop     = hs && !fifo_empty;
  assign hs_last = hs && last_q;
  assign ovf_set = (state_q == S_STREAM) && i_sample_valid && fifo_full;

  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    index_d     = index_q;
    frame_cnt_d = frame_cnt_q;
    overflow_d  = overflow_q;

    if (push) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end

    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    if (hs) begin
      index_d = (index_q == LAST_IDX) ? '0 : index_q + 1'b1;
    end
    if (hs_last) begin
      frame_cnt_d = frame_cnt_q + 16'd1;
    end

    case (state_q)
      S_IDLE: begin
        if (i_start) begin
          state_d = S_STREAM;
        end
      end
      S_STREAM: begin
        if (i_flush) begin
          state_d = S_PAD;
        end
      end
      S_PAD: begin
        // Nothing buffered and on a frame boundary: no padding required.
        // Otherwise leave only once a frame closes with the FIFO drained;
        // samples still buffered after a frame boundary start another frame
        // that is padded in turn, so every frame handed on is whole.
        if (fifo_empty && (index_q == '0)) begin
          state_d = S_IDLE;
        end else if (hs_last && (count_d == '0)) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (ovf_set) begin
      overflow_d = 1'b1;
    end
    if ((state_q == S_IDLE) && i_start) begin
      overflow_d = 1'b0;
    end
  end

  // Stream handshake flags are registered from next-state values so they
  // reflect exactly the occupancy/state that will hold in the next cycle.
  always_comb begin
    ready_d = (state_d == S_STREAM) && (count_d != DEPTH_CNT);
    valid_d = (count_d != '0) || ((state_d == S_PAD) && (index_d != '0));
    last_d  = valid_d && (index_d == LAST_IDX);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= S_IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      index_q     <= '0;
      frame_cnt_q <= '0;
      overflow_q  <= 1'b0;
      ready_q     <= 1'b0;
      valid_q     <= 1'b0;
      last_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      index_q     <= index_d;
      frame_cnt_q <= frame_cnt_d;
      overflow_q  <= overflow_d;
      ready_q     <= ready_d;
      valid_q     <= valid_d;
      last_q      <= last_d;
    end
  end

  // Sample storage carries no reset; o_data masks it whenever the FIFO is empty.
  always_ff @(posedge i_clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= i_sample;
    end
  end

  assign o_sample_ready = ready_q;
  assign o_data_valid   = valid_q;
  assign o_data_last    = last_q;
  assign o_data         = fifo_empty ? 32'h0000_0000 : {16'h0000, mem_q[rd_ptr_q]};
  assign o_frame_count  = frame_cnt_q;
  assign o_overflow     = overflow_q;
  assign o_busy         = (state_q != S_IDLE);

endmodule

// File: tb/tb_fft_input_framer.sv
// tb/tb_fft_input_framer.sv - directed self-checking bench for fft_input_framer (FRAME_LEN=8)

module tb_fft_input_framer;

  logic        clk;
  logic        i_rst_n;
  logic        i_start;
  logic        i_flush;
  logic [15:0] i_sample;
  logic        i_sample_valid;
  logic        o_sample_ready;
  logic [31:0] o_data;
  logic        o_data_valid;
  logic        i_data_ready;
  logic        o_data_last;
  logic [15:0] o_frame_count;
  logic        o_overflow;
  logic        o_busy;

  int tests_run;
  int tests_failed;

  logic [32:0] rx_q[$];

  fft_input_framer #(
    .FRAME_LEN (8),
    .LOG2_FRAME(3),
    .FIFO_DEPTH(16),
    .LOG2_DEPTH(4)
  ) dut (
    .i_clk         (clk),
    .i_rst_n       (i_rst_n),
    .i_start       (i_start),
    .i_flush       (i_flush),
    .i_sample      (i_sample),
    .i_sample_valid(i_sample_valid),
    .o_sample_ready(o_sample_ready),
    .o_data        (o_data),
    .o_data_valid  (o_data_valid),
    .i_data_ready  (i_data_ready),
    .o_data_last   (o_data_last),
    .o_frame_count (o_frame_count),
    .o_overflow    (o_overflow),
    .o_busy        (o_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (i_rst_n && o_data_valid && i_data_ready) begin
      rx_q.push_back({o_data_last, o_data});
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_dut();
    i_rst_n = 1'b0;
    tick();
    tick();
    i_rst_n = 1'b1;
    tick();
    rx_q.delete();
  endtask

  task automatic pulse_start();
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
  endtask

  task automatic flush_to_idle(input string tag);
    int cyc;
    i_flush = 1'b1;
    tick();
    i_flush = 1'b0;
    cyc = 0;
    while (o_busy && cyc < 60) begin
      tick();
      cyc++;
    end
    check({tag, "_idle"}, o_busy, 1'b0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    int pushed;
    int n_before;
    logic tog;
    logic acc;
    logic stall;
    logic [31:0] hold_data;
    logic hold_last;

    tests_run      = 0;
    tests_failed   = 0;
    i_rst_n        = 1'b0;
    i_start        = 1'b0;
    i_flush        = 1'b0;
    i_sample       = 16'h0000;
    i_sample_valid = 1'b0;
    i_data_ready   = 1'b0;

    // Reset state
    tick();
    check("rst_data",  o_data, 32'h0);
    check("rst_valid", o_data_valid, 1'b0);
    check("rst_ready", o_sample_ready, 1'b0);
    check("rst_last",  o_data_last, 1'b0);
    check("rst_count", o_frame_count, 16'h0);
    check("rst_ovf",   o_overflow, 1'b0);
    check("rst_busy",  o_busy, 1'b0);
    i_rst_n = 1'b1;
    tick();
    check("idle_ready", o_sample_ready, 1'b0);
    // flush in IDLE is ignored
    i_flush = 1'b1;
    tick();
    i_flush = 1'b0;
    check("idle_flush_busy", o_busy, 1'b0);
    pulse_start();
    check("start_busy",  o_busy, 1'b1);
    check("start_ready", o_sample_ready, 1'b1);

    // Full-rate streaming: each sample appears one cycle after its push,
    // last on the 8th and 16th word.
    i_data_ready = 1'b1;
    rx_q.delete();
    for (int k = 1; k <= 16; k++) begin
      i_sample       = 16'(k);
      i_sample_valid = 1'b1;
      tick();
      check($sformatf("stream_data%0d", k), o_data, 32'(k));
      check($sformatf("stream_last%0d", k), o_data_last, (k == 8 || k == 16) ? 1'b1 : 1'b0);
    end
    i_sample_valid = 1'b0;
    tick();
    check("stream_drained", o_data_valid, 1'b0);
    check("stream_frames", o_frame_count, 16'd2);
    check("stream_rx_n", rx_q.size(), 16);
    for (int j = 0; j < 16 && j < rx_q.size(); j++) begin
      check($sformatf("stream_rx%0d", j), rx_q[j], {(j == 7 || j == 15) ? 1'b1 : 1'b0, 32'(j + 1)});
    end

    // Index is back at 0: flush emits no pad words and returns to IDLE.
    n_before = rx_q.size();
    i_flush = 1'b1;
    tick();
    i_flush = 1'b0;
    check("flush0_pad_busy",  o_busy, 1'b1);
    check("flush0_pad_valid", o_data_valid, 1'b0);
    tick();
    check("flush0_idle", o_busy, 1'b0);
    check("flush0_no_words", rx_q.size(), n_before);
    check("flush0_frames", o_frame_count, 16'd2);

    // Partial frame of 3 samples, flushed: 3 samples then 5 zero words.
    reset_dut();
    pulse_start();
    i_data_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      i_sample       = 16'h000A + 16'(k);
      i_sample_valid = 1'b1;
      tick();
    end
    i_sample_valid = 1'b0;
    flush_to_idle("pad");
    check("pad_rx_n", rx_q.size(), 8);
    for (int j = 0; j < 8 && j < rx_q.size(); j++) begin
      check($sformatf("pad_rx%0d", j), rx_q[j],
            {(j == 7) ? 1'b1 : 1'b0, (j < 3) ? 32'h0000_000A + 32'(j) : 32'h0});
    end
    check("pad_frames", o_frame_count, 16'd1);
    check("pad_valid_after", o_data_valid, 1'b0);

    // Overflow: 17 samples into a 16-deep FIFO with the output stalled.
    reset_dut();
    pulse_start();
    i_data_ready = 1'b0;
    for (int k = 0; k < 16; k++) begin
      i_sample       = 16'h0100 + 16'(k);
      i_sample_valid = 1'b1;
      tick();
    end
    check("full_ready", o_sample_ready, 1'b0);
    check("full_ovf_pre", o_overflow, 1'b0);
    i_sample       = 16'h0110;
    i_sample_valid = 1'b1;
    tick();
    i_sample_valid = 1'b0;
    check("full_ovf", o_overflow, 1'b1);
    check("full_head", o_data, 32'h0000_0100);
    i_data_ready = 1'b1;
    tick();
    check("ready_after_pop", o_sample_ready, 1'b1);
    cyc = 0;
    while (rx_q.size() < 16 && cyc < 60) begin
      tick();
      cyc++;
    end
    tick();
    check("ovf_rx_n", rx_q.size(), 16);
    for (int j = 0; j < 16 && j < rx_q.size(); j++) begin
      check($sformatf("ovf_rx%0d", j), rx_q[j], {(j == 7 || j == 15) ? 1'b1 : 1'b0, 32'h0000_0100 + 32'(j)});
    end
    pulse_start();
    check("ovf_sticky", o_overflow, 1'b1);
    flush_to_idle("ovf");
    pulse_start();
    check("ovf_cleared", o_overflow, 1'b0);
    check("ovf_frames", o_frame_count, 16'd2);

    // Downstream ready toggling every cycle with input offered every cycle.
    rx_q.delete();
    pushed = 0;
    cyc    = 0;
    tog    = 1'b0;
    while ((pushed < 24 || rx_q.size() < 24) && cyc < 400) begin
      i_data_ready = tog;
      tog = ~tog;
      if (pushed < 24) begin
        i_sample       = 16'h0200 + 16'(pushed);
        i_sample_valid = 1'b1;
      end else begin
        i_sample_valid = 1'b0;
      end
      acc       = i_sample_valid && o_sample_ready;
      stall     = o_data_valid && !i_data_ready;
      hold_data = o_data;
      hold_last = o_data_last;
      tick();
      if (acc) pushed++;
      if (stall) begin
        check("hold_data",  o_data, hold_data);
        check("hold_last",  o_data_last, hold_last);
        check("hold_valid", o_data_valid, 1'b1);
      end
      cyc++;
    end
    i_sample_valid = 1'b0;
    i_data_ready   = 1'b1;
    tick();
    check("tog_rx_n", rx_q.size(), 24);
    for (int j = 0; j < 24 && j < rx_q.size(); j++) begin
      check($sformatf("tog_rx%0d", j), rx_q[j],
            {(j % 8 == 7) ? 1'b1 : 1'b0, 32'h0000_0200 + 32'(j)});
    end
    check("tog_frames", o_frame_count, 16'd5);

    // Reset asserted mid-frame clears outputs without a clock edge.
    i_data_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      i_sample       = 16'h0300 + 16'(k);
      i_sample_valid = 1'b1;
      tick();
    end
    i_sample_valid = 1'b0;
    check("mid_valid_pre", o_data_valid, 1'b1);
    #2;
    i_rst_n = 1'b0;
    #1;
    check("mid_rst_data",  o_data, 32'h0);
    check("mid_rst_valid", o_data_valid, 1'b0);
    check("mid_rst_ready", o_sample_ready, 1'b0);
    check("mid_rst_last",  o_data_last, 1'b0);
    check("mid_rst_count", o_frame_count, 16'h0);
    check("mid_rst_busy",  o_busy, 1'b0);
    #1;
    i_rst_n = 1'b1;
    tick();
    tick();
    tick();
    check("post_rst_ready", o_sample_ready, 1'b0);
    check("post_rst_busy",  o_busy, 1'b0);
    check("post_rst_valid", o_data_valid, 1'b0);
    pulse_start();
    check("post_rst_start_ready", o_sample_ready, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
